// File: rtl/opb_arb_pkg.sv
// Shared types and helpers for the OPB master arbiter and its round-robin picker.
package opb_arb_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    BUSY    = 2'd2
  } arb_state_e;

  // Counter widths cover the largest legal TIMEOUT_CYCLES / GRANT_WAIT values.
  localparam int TOUT_CNT_W = 8;
  localparam int WAIT_CNT_W = 8;

  // Ceiling log2 for elaboration-time width calculation.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/opb_rr_pick.sv
// Combinational round-robin picker: the first requester after 'last'
// (wrapping modulo N) wins. Reusable by any arbiter with an index register.
module opb_rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

  logic [IDX_W-1:0] idx_s;

  // Scan from the farthest offset to the nearest so the nearest requester overrides.
  always_comb begin
    winner = last;
    valid  = 1'b0;
    idx_s  = last;
    for (int k = N; k >= 1; k--) begin
      idx_s = IDX_W'((int'(last) + k) % N);
      if (req[idx_s]) begin
        winner = idx_s;
        valid  = 1'b1;
      end else begin
        winner = winner;
        valid  = valid;
      end
    end
  end

endmodule

// File: rtl/opb_master_arbiter.sv
// Round-robin OPB master arbiter with bus-lock, grant-wait withdrawal and
// a per-transfer bus timeout monitor. No parking: idle bus means no grant.
module opb_master_arbiter
  import opb_arb_pkg::*;
#(
  parameter  int NUM_MASTERS    = 2,
  parameter  int TIMEOUT_CYCLES = 16,
  parameter  int GRANT_WAIT     = 8,
  localparam int IDX_W          = (clog2(NUM_MASTERS) < 1) ? 1 : clog2(NUM_MASTERS)
) (
  input  logic                   OPB_Clk,
  input  logic                   OPB_Rst_n,
  input  logic [NUM_MASTERS-1:0] M_request,
  input  logic [NUM_MASTERS-1:0] M_busLock,
  input  logic [NUM_MASTERS-1:0] M_select,
  input  logic                   OPB_xferAck,
  input  logic                   OPB_errAck,
  input  logic                   OPB_retry,
  input  logic                   OPB_toutSup,
  output logic [NUM_MASTERS-1:0] OPB_MGrant,
  output logic                   OPB_select,
  output logic                   OPB_timeout,
  output logic [IDX_W-1:0]       cur_master
);

  localparam logic [IDX_W-1:0]       LAST_INIT = IDX_W'(NUM_MASTERS - 1);
  localparam logic [TOUT_CNT_W-1:0]  TOUT_LAST = TOUT_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WAIT_CNT_W-1:0]  WAIT_LAST = WAIT_CNT_W'(GRANT_WAIT - 1);
  localparam logic [NUM_MASTERS-1:0] ONE_HOT0  = {{(NUM_MASTERS-1){1'b0}}, 1'b1};
  localparam logic [NUM_MASTERS-1:0] NO_GRANT  = {NUM_MASTERS{1'b0}};

  arb_state_e             state_r, state_s;
  logic [NUM_MASTERS-1:0] grant_r, grant_s;
  logic [IDX_W-1:0]       owner_r, owner_s;
  logic [IDX_W-1:0]       last_r, last_s;
  logic [TOUT_CNT_W-1:0]  tout_cnt_r, tout_cnt_s;
  logic [WAIT_CNT_W-1:0]  wait_cnt_r, wait_cnt_s;
  logic                   timeout_r, timeout_s;

  logic [IDX_W-1:0]       pick_idx_s;
  logic                   pick_valid_s;
  logic                   owner_sel_s;
  logic                   owner_req_s;
  logic                   owner_lock_s;
  logic                   bus_active_s;
  logic                   any_ack_s;

  opb_rr_pick #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (M_request),
    .last   (last_r),
    .winner (pick_idx_s),
    .valid  (pick_valid_s)
  );

  // Owner-qualified views of the master inputs; only the owner's bits matter.
  always_comb begin
    owner_sel_s  = M_select[owner_r];
    owner_req_s  = M_request[owner_r];
    owner_lock_s = M_busLock[owner_r];
    bus_active_s = (state_r == GRANTED) || (state_r == BUSY);
    any_ack_s    = OPB_xferAck | OPB_errAck | OPB_retry | OPB_toutSup;
  end

  assign OPB_select  = owner_sel_s & bus_active_s;
  assign OPB_MGrant  = grant_r;
  assign OPB_timeout = timeout_r;
  assign cur_master  = owner_r;

  // Next-state, grant, round-robin pointer and counter update logic.
  always_comb begin
    state_s    = state_r;
    grant_s    = grant_r;
    owner_s    = owner_r;
    last_s     = last_r;
    tout_cnt_s = tout_cnt_r;
    wait_cnt_s = wait_cnt_r;
    timeout_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          state_s    = GRANTED;
          grant_s    = ONE_HOT0 << pick_idx_s;
          owner_s    = pick_idx_s;
          wait_cnt_s = {WAIT_CNT_W{1'b0}};
        end else begin
          grant_s = NO_GRANT;
        end
      end
      GRANTED: begin
        if (owner_sel_s) begin
          state_s    = BUSY;
          tout_cnt_s = {TOUT_CNT_W{1'b0}};
        end else if (!owner_req_s) begin
          state_s = IDLE;
          grant_s = NO_GRANT;
        end else if (wait_cnt_r == WAIT_LAST) begin
          // Owner never selected: release and rotate so others are not starved.
          state_s = IDLE;
          grant_s = NO_GRANT;
          last_s  = owner_r;
        end else begin
          wait_cnt_s = wait_cnt_r + 8'd1;
        end
      end
      BUSY: begin
        if (!owner_sel_s) begin
          tout_cnt_s = {TOUT_CNT_W{1'b0}};
          if (owner_lock_s) begin
            // Locked owner keeps the bus for its next transfer without arbitration.
            state_s    = GRANTED;
            wait_cnt_s = {WAIT_CNT_W{1'b0}};
          end else begin
            state_s = IDLE;
            grant_s = NO_GRANT;
            last_s  = owner_r;
          end
        end else if (any_ack_s) begin
          // Ack takes priority over a terminal count in the same cycle.
          tout_cnt_s = {TOUT_CNT_W{1'b0}};
        end else if (tout_cnt_r == TOUT_LAST) begin
          timeout_s  = 1'b1;
          tout_cnt_s = {TOUT_CNT_W{1'b0}};
        end else begin
          tout_cnt_s = tout_cnt_r + 8'd1;
        end
      end
      default: begin
        state_s = IDLE;
        grant_s = NO_GRANT;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      state_r    <= IDLE;
      grant_r    <= NO_GRANT;
      owner_r    <= LAST_INIT;
      last_r     <= LAST_INIT;
      tout_cnt_r <= {TOUT_CNT_W{1'b0}};
      wait_cnt_r <= {WAIT_CNT_W{1'b0}};
      timeout_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      grant_r    <= grant_s;
      owner_r    <= owner_s;
      last_r     <= last_s;
      tout_cnt_r <= tout_cnt_s;
      wait_cnt_r <= wait_cnt_s;
      timeout_r  <= timeout_s;
    end
  end

endmodule
